// File: rtl/lap_capture_fifo.sv
// Lap capture FIFO: snapshots count_in on each rising edge of save into a
// first-word-fall-through queue tagged with a running lap index.
module lap_capture_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDXW  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             count_in,
  input  logic                         save,
  output logic [WIDTH-1:0]             out_data,
  output logic [IDXW-1:0]              out_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  input  logic                         clr_ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_mem_q [DEPTH];
  logic [WIDTH-1:0] data_mem_d [DEPTH];
  logic [IDXW-1:0]  idx_mem_q  [DEPTH];
  logic [IDXW-1:0]  idx_mem_d  [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [IDXW-1:0]  lap_cnt_q, lap_cnt_d;
  logic             save_d_q, save_d_d;
  logic             overflow_q, overflow_d;

  logic cap, pop, push, drop, full, empty;

  // Handshake decode; full/empty come from the level register only.
  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == LW'(DEPTH));
    cap   = save & ~save_d_q;
    pop   = ~empty & out_ready;
    push  = cap & (~full | pop);
    drop  = cap & full & ~pop;
  end

  always_comb begin
    save_d_d   = save;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    lap_cnt_d  = lap_cnt_q;
    overflow_d = overflow_q;
    data_mem_d = data_mem_q;
    idx_mem_d  = idx_mem_q;

    if (push) begin
      data_mem_d[wr_ptr_q] = count_in;
      idx_mem_d[wr_ptr_q]  = lap_cnt_q + IDXW'(1);
      lap_cnt_d            = lap_cnt_q + IDXW'(1);
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      save_d_q   <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      lap_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      save_d_q   <= save_d_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      lap_cnt_q  <= lap_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; validity is tracked by level_q.
  always_ff @(posedge clk) begin
    data_mem_q <= data_mem_d;
    idx_mem_q  <= idx_mem_d;
  end

  always_comb begin
    out_valid = ~empty;
    out_data  = empty ? '0 : data_mem_q[rd_ptr_q];
    out_idx   = empty ? '0 : idx_mem_q[rd_ptr_q];
    level     = level_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_lap_capture_fifo.sv
// Bench for lap_capture_fifo: two instances (IDXW=8 and IDXW=2) share one
// stimulus stream and are checked against a queue-based reference model.
module tb_lap_capture_fifo;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] count_in;
  logic             save;
  logic             out_ready;
  logic             clr_ovf;

  logic [WIDTH-1:0] a_data, b_data;
  logic [7:0]       a_idx;
  logic [1:0]       b_idx;
  logic             a_valid, b_valid;
  logic [LW-1:0]    a_level, b_level;
  logic             a_ovf, b_ovf;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  lap_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(8)) dut_a (
    .clk(clk), .rst(rst), .count_in(count_in), .save(save),
    .out_data(a_data), .out_idx(a_idx), .out_valid(a_valid),
    .out_ready(out_ready), .level(a_level), .overflow(a_ovf),
    .clr_ovf(clr_ovf)
  );

  lap_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(2)) dut_b (
    .clk(clk), .rst(rst), .count_in(count_in), .save(save),
    .out_data(b_data), .out_idx(b_idx), .out_valid(b_valid),
    .out_ready(out_ready), .level(b_level), .overflow(b_ovf),
    .clr_ovf(clr_ovf)
  );

  // Reference model: queue of {lap number, data}, lap number unbounded.
  typedef struct {
    int unsigned lap;
    int unsigned data;
  } entry_t;

  entry_t      exp_q[$];
  int unsigned m_lap  = 0;
  bit          m_ovf  = 1'b0;
  bit          m_prev = 1'b1;

  always @(posedge clk) begin
    bit     cap, popped, dropped;
    entry_t e;
    if (rst) begin
      exp_q.delete();
      m_lap  = 0;
      m_ovf  = 1'b0;
      m_prev = 1'b1;
    end else begin
      cap     = save && !m_prev;
      m_prev  = save;
      popped  = (exp_q.size() > 0) && out_ready;
      dropped = 1'b0;
      if (popped) void'(exp_q.pop_front());
      if (cap) begin
        if (exp_q.size() < DEPTH) begin
          m_lap  = m_lap + 1;
          e.lap  = m_lap;
          e.data = count_in;
          exp_q.push_back(e);
        end else begin
          dropped = 1'b1;
        end
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Monitor: compares both instances' visible state with the model head.
  always @(negedge clk) begin
    int unsigned e_lvl, e_dat, e_lap;
    if (mon_en) begin
      e_lvl = exp_q.size();
      e_dat = (e_lvl > 0) ? exp_q[0].data : 0;
      e_lap = (e_lvl > 0) ? exp_q[0].lap : 0;
      chk("a_valid", 32'(a_valid), (e_lvl > 0) ? 1 : 0);
      chk("a_level", 32'(a_level), e_lvl);
      chk("a_data",  32'(a_data),  e_dat);
      chk("a_idx",   32'(a_idx),   e_lap % 256);
      chk("a_ovf",   32'(a_ovf),   32'(m_ovf));
      chk("b_valid", 32'(b_valid), (e_lvl > 0) ? 1 : 0);
      chk("b_level", 32'(b_level), e_lvl);
      chk("b_data",  32'(b_data),  e_dat);
      chk("b_idx",   32'(b_idx),   e_lap % 4);
      chk("b_ovf",   32'(b_ovf),   32'(m_ovf));
    end
  end

  task automatic step(input logic s, input logic [WIDTH-1:0] c, input logic rd,
                      input logic cl, input logic r);
    save = s; count_in = c; out_ready = rd; clr_ovf = cl; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [WIDTH-1:0] c, input logic rd);
    step(1'b1, c, rd, 1'b0, 1'b0);
    step(1'b0, c, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    save = 1'b1; count_in = '0; out_ready = 1'b0; clr_ovf = 1'b0; rst = 1'b1;
    // Save held high through reset release must not capture.
    step(1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    step(1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h5, 1'b0, 1'b0, 1'b0);

    // Single capture then pop.
    step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Held save captures once.
    for (int i = 0; i < 10; i++) step(1'b1, 4'(3 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    drain(2);

    // Fill, overflow, drain, sixth pulse.
    pulse(4'h1, 1'b0); pulse(4'h2, 1'b0); pulse(4'h3, 1'b0);
    pulse(4'h4, 1'b0); pulse(4'h9, 1'b0);
    drain(4);
    pulse(4'h6, 1'b0);
    drain(2);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Full with a pop on the capture cycle.
    pulse(4'h1, 1'b0); pulse(4'h2, 1'b0); pulse(4'h3, 1'b0); pulse(4'h4, 1'b0);
    step(1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    drain(5);

    // Backpressure, then clear colliding with a drop, then clear alone.
    pulse(4'ha, 1'b0); pulse(4'hb, 1'b0);
    repeat (5) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    pulse(4'hc, 1'b0); pulse(4'hd, 1'b0);
    step(1'b1, 4'h8, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Mid-run reset with entries stored, then a fresh capture.
    drain(4);
    pulse(4'h1, 1'b0); pulse(4'h2, 1'b0); pulse(4'h3, 1'b0);
    step(1'b1, 4'h5, 1'b1, 1'b1, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    pulse(4'he, 1'b0);
    drain(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 199) == 0));
    end

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lap_capture_fifo.md
Name: lap_capture_fifo

Overview:
- Sits downstream of the 4-bit ripple counter with save register.
- Takes the live counter value and the `save` strobe, and captures one counter snapshot per rising edge of `save`.
- Holds snapshots in a small first-word-fall-through FIFO, so a display or UART stage can drain recorded laps with a valid/ready handshake.
- Adds overflow reporting and a running count of accepted laps.

Parameters:
- WIDTH, 4: bit width of the counter value captured.
- DEPTH, 4: number of FIFO entries; must be a power of two and at least 2.
- IDXW, 8: width of the running lap index.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- count_in  input  WIDTH  live counter value to snapshot.
- save  input  1  capture request (level); only its rising edge, as sampled on clk, triggers a capture.
- out_data  output  WIDTH  snapshot at the FIFO head; 0 when empty.
- out_idx  output  IDXW  lap index of the head entry; 0 when empty.
- out_valid  output  1  high when FIFO is non-empty.
- out_ready  input  1  consumer accepts the head entry when out_valid and out_ready are both high.
- level  output  clog2(DEPTH+1)  current number of stored entries.
- overflow  output  1  sticky flag: a capture was dropped because the FIFO was full.
- clr_ovf  input  1  clears overflow on the next edge.

Behaviour:
- Reset (rst=1 at posedge):
  - Read and write pointers = 0, level = 0.
  - out_valid = 0, out_data = 0, out_idx = 0.
  - overflow = 0.
  - Lap counter = 0.
  - save_d = 1, so a save held high through reset produces no capture.
  - Storage array contents are don't-care.
- Edge detect:
  - save_d <= save every cycle.
  - cap = save & ~save_d.
  - The capture uses the count_in value present on the same cycle cap is high.
- Push:
  - A push occurs when cap=1 and (level<DEPTH, or a pop occurs on the same cycle).
  - The entry is {lap_cnt+1, count_in}; lap_cnt then increments and wraps modulo 2^IDXW.
  - The first lap is index 1.
- Pop: occurs when out_valid & out_ready; the read pointer advances.
- Simultaneous push and pop:
  - Both occur and level is unchanged.
  - This applies even when full, because the pop frees the slot.
  - When the FIFO is empty, no pop is possible; the push lands and out_valid rises on the next cycle.
- Drop: cap=1, level==DEPTH and no pop in that cycle means the entry is not written, lap_cnt does not increment, and overflow <= 1.
- overflow:
  - Clears only via rst, or clr_ovf=1 at posedge.
  - If clr_ovf and a drop occur in the same cycle, set wins (overflow stays 1).
- Latency:
  - A capture on posedge N makes out_valid / out_data / out_idx / level reflect it after posedge N.
  - Outputs are registered-state derived, with no combinational path from save or count_in.
- Head outputs:
  - out_data and out_idx are driven from the head entry when level>0, otherwise 0.
  - They must stay stable while out_valid=1 and out_ready=0.
- Pointer arithmetic:
  - Pointers are clog2(DEPTH) bits and wrap naturally.
  - Full and empty are distinguished by the level register, not by pointer equality.
- out_ready while empty has no effect.
- Reset asserted mid-operation discards all stored entries on that edge, regardless of other inputs.

Test Plan:
- Single capture: reset; count_in=4'h5; pulse save for 1 cycle → next cycle out_valid=1, out_data=5, out_idx=1, level=1. Then out_ready=1 for 1 cycle → out_valid=0, out_data=0, level=0.
- Held save: save high for 10 cycles while count_in steps 3,4,5… → exactly one entry with out_data=3, out_idx=1. Also, save held high across reset release → no entry.
- Fill and overflow (DEPTH=4, out_ready=0):
  - 5 save pulses with count_in 1,2,3,4,9 → level=4 and overflow=1.
  - Draining yields data 1,2,3,4 with idx 1,2,3,4.
  - A sixth pulse after draining gets idx 5.
- Full with simultaneous pop: FIFO full with 1..4; save edge with count_in=7 and out_ready=1 in the same cycle → level stays 4, overflow stays 0, drain order is 2,3,4,7.
- Backpressure stability: 2 entries, out_ready=0 for 5 cycles → out_data and out_idx unchanged. Then clr_ovf pulse coinciding with a drop on a full FIFO → overflow remains 1; a clr_ovf pulse alone afterwards → overflow=0.
- Index wrap and mid-run reset:
  - IDXW=2: 5 captures (draining as needed) → idx sequence 1,2,3,0,1.
  - Assert rst with 3 entries stored → level=0, out_valid=0 after that edge; the next capture gets idx 1.
